// File: rtl/sms_request_arbiter.sv
// Fixed-priority arbiter for four SMS request sources feeding one GSM sender.
// Latches request edges, grants one source, strobes load, holds start, waits, then gaps.
module sms_request_arbiter #(
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic       sms_done,
    output logic [1:0] sel,
    output logic       load,
    output logic       start,
    output logic [3:0] pending,
    output logic       busy,
    output logic       err_timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       prev_q;
    logic [3:0]       evt_q;
    logic [3:0]       pend_q, pend_d;
    logic [1:0]       sel_q, sel_d;
    logic             load_q, start_q, busy_q, err_q;
    logic             err_d;
    logic [3:0]       clr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        clr     = 4'b0000;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    state_d = S_LOAD;
                    // fire > gas > smoke > delivery
                    if (pend_q[1])      sel_d = 2'd1;
                    else if (pend_q[2]) sel_d = 2'd2;
                    else if (pend_q[3]) sel_d = 2'd3;
                    else                sel_d = 2'd0;
                    clr = 4'b0001 << sel_d;
                end
            end
            S_LOAD: begin
                cnt_d   = HOLD_LD;
                state_d = S_START;
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = TMO_LD;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_WAIT: begin
                if (sms_done) begin
                    cnt_d   = GAP_LD;
                    state_d = S_GAP;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    cnt_d   = GAP_LD;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - ONE;
            end
            default: state_d = S_IDLE;
        endcase
        // a new event on the source being granted keeps its flag
        pend_d = (pend_q & ~clr) | evt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prev_q  <= 4'b0000;
            evt_q   <= 4'b0000;
            pend_q  <= 4'b0000;
            sel_q   <= 2'd0;
            load_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= req_in;
            evt_q   <= req_in & ~prev_q;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            load_q  <= (state_d == S_LOAD);
            start_q <= (state_d == S_START);
            busy_q  <= (state_d != S_IDLE);
            err_q   <= err_d;
        end
    end

    assign sel         = sel_q;
    assign load        = load_q;
    assign start       = start_q;
    assign pending     = pend_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_sms_request_arbiter.sv
// Directed bench for sms_request_arbiter with HOLD=4, GAP=8, TIMEOUT=100.
// Inputs change 1ns after posedge; outputs are checked at the same point.
module tb_sms_request_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_in = 4'b0000;
    logic       sms_done = 1'b0;
    logic [1:0] sel;
    logic       load, start, busy, err_timeout;
    logic [3:0] pending;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sms_request_arbiter #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES(8),
        .TIMEOUT_CYCLES(100),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_in(req_in),
        .sms_done(sms_done),
        .sel(sel),
        .load(load),
        .start(start),
        .pending(pending),
        .busy(busy),
        .err_timeout(err_timeout),
        .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
        int n = 0;
        while (state !== s && n < bound) begin
            step();
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic wait_load(input int bound, output logic [1:0] s, input string tag);
        int n = 0;
        while (load !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        chk(tag, 32'(load), 32'd1);
        s = sel;
    endtask

    task automatic serve(input string tag);
        wait_state(3'd3, 60, tag);
        sms_done = 1'b1;
        step();
        sms_done = 1'b0;
        wait_state(3'd0, 60, tag);
    endtask

    initial begin
        int cnt, g, p, nl;
        logic [1:0] s;
        logic [1:0] sels [4];
        int tl [4];

        // reset state
        repeat (3) step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        rst_n = 1'b1;
        step();

        // single request on gas
        req_in = 4'b0100;
        step();
        chk("t1_pend_early", 32'(pending), 32'd0);
        step();
        chk("t1_pend", 32'(pending), 32'b0100);
        chk("t1_idle", 32'(state), 32'd0);
        req_in = 4'b0000;
        step();
        chk("t1_load", 32'(load), 32'd1);
        chk("t1_sel", 32'(sel), 32'd2);
        chk("t1_state_load", 32'(state), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_pend_clr", 32'(pending), 32'd0);
        cnt = 0;
        step();
        while (start && cnt < 20) begin
            cnt++;
            step();
        end
        chk("t1_start_len", 32'(cnt), 32'd4);
        chk("t1_wait", 32'(state), 32'd3);
        chk("t1_load_once", 32'(load), 32'd0);
        repeat (9) step();
        sms_done = 1'b1;
        step();
        sms_done = 1'b0;
        chk("t1_gap", 32'(state), 32'd4);
        chk("t1_no_err", 32'(err_timeout), 32'd0);
        g = 0;
        while (state == 3'd4 && g < 50) begin
            g++;
            step();
        end
        chk("t1_gap_len", 32'(g), 32'd8);
        chk("t1_idle_end", 32'(state), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // all four at once: order 1,2,3,0 with 15-cycle load spacing
        req_in = 4'b1111;
        step();
        req_in = 4'b0000;
        nl = 0;
        for (int c = 0; c < 200 && !(nl == 4 && state == 3'd0); c++) begin
            sms_done = (state == 3'd3);
            step();
            if (load) begin
                if (nl < 4) begin
                    sels[nl] = sel;
                    tl[nl] = c;
                end
                nl++;
            end
        end
        sms_done = 1'b0;
        chk("t2_nloads", 32'(nl), 32'd4);
        chk("t2_sel0", 32'(sels[0]), 32'd1);
        chk("t2_sel1", 32'(sels[1]), 32'd2);
        chk("t2_sel2", 32'(sels[2]), 32'd3);
        chk("t2_sel3", 32'(sels[3]), 32'd0);
        for (int i = 1; i < 4; i++)
            chk("t2_spacing", 32'(tl[i] - tl[i-1]), 32'd15);
        chk("t2_pend_end", 32'(pending), 32'd0);

        // timeout on delivery; sms_done in START ignored
        req_in = 4'b0001;
        step();
        req_in = 4'b0000;
        wait_load(10, s, "t3_load");
        chk("t3_sel", 32'(s), 32'd0);
        step();
        chk("t3_start", 32'(state), 32'd2);
        sms_done = 1'b1;
        step();
        sms_done = 1'b0;
        chk("t3_done_ignored", 32'(state), 32'd2);
        wait_state(3'd3, 10, "t3_wait");
        cnt = 0;
        while (!err_timeout && cnt < 200) begin
            step();
            cnt++;
        end
        chk("t3_tmo_delay", 32'(cnt), 32'd100);
        chk("t3_gap", 32'(state), 32'd4);
        g = 0;
        p = 0;
        while (state == 3'd4 && g < 50) begin
            p += int'(err_timeout);
            g++;
            step();
        end
        chk("t3_gap_len", 32'(g), 32'd8);
        chk("t3_err_once", 32'(p), 32'd1);
        chk("t3_idle", 32'(state), 32'd0);

        // merge three fire edges while busy, then re-request during WAIT
        req_in = 4'b1000;
        step();
        req_in = 4'b0000;
        wait_load(10, s, "t4_load_smoke");
        chk("t4_sel_smoke", 32'(s), 32'd3);
        for (int i = 0; i < 3; i++) begin
            req_in = 4'b0010;
            step();
            req_in = 4'b0000;
            step();
        end
        chk("t4_merged", 32'(pending), 32'b0010);
        chk("t4_in_wait", 32'(state), 32'd3);
        sms_done = 1'b1;
        step();
        sms_done = 1'b0;
        wait_load(30, s, "t4_load_fire");
        chk("t4_sel_fire", 32'(s), 32'd1);
        chk("t4_pend_clr", 32'(pending), 32'd0);
        wait_state(3'd3, 20, "t4_wait_fire");
        req_in = 4'b0010;
        step();
        req_in = 4'b0000;
        step();
        chk("t4_rereq", 32'(pending), 32'b0010);
        sms_done = 1'b1;
        step();
        sms_done = 1'b0;
        wait_load(30, s, "t4_load_fire2");
        chk("t4_sel_fire2", 32'(s), 32'd1);
        serve("t4_serve");
        nl = 0;
        repeat (5) begin
            step();
            nl += int'(load);
        end
        chk("t4_no_extra", 32'(nl), 32'd0);
        chk("t4_pend_end", 32'(pending), 32'd0);

        // reset mid-START with smoke pending; held smoke line re-requests once
        req_in = 4'b0010;
        step();
        req_in = 4'b0000;
        wait_load(10, s, "t5_load");
        req_in = 4'b1000;
        step();
        step();
        chk("t5_in_start", 32'(state), 32'd2);
        chk("t5_pend", 32'(pending), 32'b1000);
        rst_n = 1'b0;
        step();
        chk("t5_start_drop", 32'(start), 32'd0);
        chk("t5_state", 32'(state), 32'd0);
        chk("t5_pend_lost", 32'(pending), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        nl = 0;
        s = 2'd0;
        for (int c = 0; c < 60; c++) begin
            sms_done = (state == 3'd3);
            step();
            if (load) begin
                nl++;
                s = sel;
            end
        end
        sms_done = 1'b0;
        req_in = 4'b0000;
        chk("t5_one_grant", 32'(nl), 32'd1);
        chk("t5_sel", 32'(s), 32'd3);
        chk("t5_idle", 32'(state), 32'd0);

        // fire edge lands in the IDLE cycle that grants fire
        req_in = 4'b0001;
        step();
        req_in = 4'b0000;
        wait_load(10, s, "t6_load0");
        chk("t6_sel0", 32'(s), 32'd0);
        req_in = 4'b0010;
        step();
        req_in = 4'b0000;
        wait_state(3'd3, 20, "t6_wait");
        sms_done = 1'b1;
        step();
        sms_done = 1'b0;
        chk("t6_gap", 32'(state), 32'd4);
        chk("t6_pend", 32'(pending), 32'b0010);
        repeat (7) step();
        chk("t6_gap_last", 32'(state), 32'd4);
        req_in = 4'b0010;
        step();
        chk("t6_idle", 32'(state), 32'd0);
        chk("t6_pend_idle", 32'(pending), 32'b0010);
        req_in = 4'b0000;
        step();
        chk("t6_grant", 32'(state), 32'd1);
        chk("t6_sel1", 32'(sel), 32'd1);
        chk("t6_set_wins", 32'(pending), 32'b0010);
        serve("t6_serve1");
        wait_load(10, s, "t6_load2");
        chk("t6_sel2", 32'(s), 32'd1);
        chk("t6_pend_clr", 32'(pending), 32'd0);
        serve("t6_serve2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
